// File: rtl/lvds_pkg.sv
// Shared types and constants for the LVDS transmit framer.
// Holds the link state encoding, default framing words and PRBS7 constants.
package lvds_pkg;

  typedef enum logic [1:0] {
    TX_TRAIN = 2'd0,
    TX_SYNC  = 2'd1,
    TX_DATA  = 2'd2
  } tx_state_e;

  localparam logic [1:0] ST_TRAIN = TX_TRAIN;
  localparam logic [1:0] ST_SYNC  = TX_SYNC;
  localparam logic [1:0] ST_DATA  = TX_DATA;

  localparam logic [9:0] DEF_TRAIN_PATTERN = 10'h3E0;
  localparam logic [9:0] DEF_SYNC_WORD     = 10'h17C;
  localparam logic [9:0] DEF_IDLE_WORD     = 10'h3E0;

  // PRBS7 = x^7 + x^6 + 1: feedback from the two most significant taps
  localparam logic [6:0] PRBS7_SEED   = 7'h7F;
  localparam int         PRBS7_TAP_HI = 6;
  localparam int         PRBS7_TAP_LO = 5;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lvds_tx_framer_prbs7_gen.sv
// Parallel PRBS7 generator: DATA_WIDTH successive sequence bits per clk, MSB first.
// Only instantiated when LVDS_TX_PRBS_EN is defined.
module lvds_prbs7_gen
  import lvds_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_adv,
  output logic [DATA_WIDTH-1:0] o_word
);

  logic [6:0] r_lfsr;
  logic [6:0] w_lfsr_nxt;

  always_comb begin
    logic [6:0] v_lfsr;
    logic       v_bit;
    v_lfsr = r_lfsr;
    v_bit  = 1'b0;
    o_word = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      v_bit                   = v_lfsr[PRBS7_TAP_HI] ^ v_lfsr[PRBS7_TAP_LO];
      o_word[DATA_WIDTH-1-i]  = v_bit;
      v_lfsr                  = {v_lfsr[5:0], v_bit};
    end
    w_lfsr_nxt = v_lfsr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= PRBS7_SEED;
    end else if (i_load) begin
      r_lfsr <= PRBS7_SEED;
    end else if (i_adv) begin
      r_lfsr <= w_lfsr_nxt;
    end
  end

endmodule

// File: rtl/lvds_tx_framer.sv
// Word-rate LVDS transmit framer: training pattern, sync burst, then payload stream.
// Optional far-end BER source enabled by defining LVDS_TX_PRBS_EN (adds prbs_en).
//
// state | meaning
// TRAIN | send TRAIN_PATTERN, count words (saturating) until TRAIN_MIN and far end aligned
// SYNC  | send SYNC_REPEAT x SYNC_WORD; any loss of alignment or train_req aborts to TRAIN
// DATA  | stream payload on valid/ready, IDLE_WORD in gaps; link_up high
module lvds_tx_framer
  import lvds_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 10,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(DEF_TRAIN_PATTERN),
  parameter int                    TRAIN_MIN     = 256,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD     = DATA_WIDTH'(DEF_SYNC_WORD),
  parameter int                    SYNC_REPEAT   = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD     = DATA_WIDTH'(DEF_IDLE_WORD)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  train_req,
  input  logic                  rx_aligned,
`ifdef LVDS_TX_PRBS_EN
  input  logic                  prbs_en,
`endif
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  link_up,
  output logic [1:0]            tx_state
);

  localparam int                CNT_W       = $clog2(max2(TRAIN_MIN, SYNC_REPEAT) + 1);
  localparam logic [CNT_W-1:0]  TRAIN_MIN_C = CNT_W'(TRAIN_MIN);
  localparam logic [CNT_W-1:0]  SYNC_LAST_C = CNT_W'(SYNC_REPEAT - 1);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [CNT_W-1:0]      w_train_cnt;
  logic [DATA_WIDTH-1:0] w_tx_nxt;
  logic [DATA_WIDTH-1:0] w_prbs_word;
  logic                  w_retrain;
  logic                  w_xfer;
  logic                  w_prbs_on;

`ifdef LVDS_TX_PRBS_EN
  logic w_prbs_load;
  logic w_prbs_adv;

  assign w_prbs_on   = prbs_en;
  // Reseed on the edge that enters DATA so every BER run starts from the same point
  assign w_prbs_load = (r_state != ST_DATA) & (w_state_nxt == ST_DATA);
  assign w_prbs_adv  = (r_state == ST_DATA) & prbs_en & ~w_retrain;

  lvds_prbs7_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_prbs7 (
    .clk   (clk),
    .reset (reset),
    .i_load(w_prbs_load),
    .i_adv (w_prbs_adv),
    .o_word(w_prbs_word)
  );
`else
  assign w_prbs_on   = 1'b0;
  assign w_prbs_word = '0;
`endif

  assign w_retrain = train_req | ~rx_aligned;
  assign s_tready  = (r_state == ST_DATA) & ~train_req & rx_aligned & ~w_prbs_on;
  assign w_xfer    = s_tvalid & s_tready;
  assign tx_state  = r_state;

  // The exit test looks at the incremented count so the TRAIN_MIN-th word is the last one
  assign w_train_cnt = (r_cnt == TRAIN_MIN_C) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tx_nxt    = IDLE_WORD;
    case (r_state)
      ST_TRAIN: begin
        w_tx_nxt  = TRAIN_PATTERN;
        w_cnt_nxt = w_train_cnt;
        if ((w_train_cnt == TRAIN_MIN_C) && !w_retrain) begin
          w_state_nxt = ST_SYNC;
          w_cnt_nxt   = '0;
        end
      end
      ST_SYNC: begin
        w_tx_nxt = SYNC_WORD;
        if (w_retrain) begin
          w_state_nxt = ST_TRAIN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == SYNC_LAST_C) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_retrain) begin
          w_state_nxt = ST_TRAIN;
          w_cnt_nxt   = '0;
        end else if (w_prbs_on) begin
          w_tx_nxt = w_prbs_word;
        end else if (w_xfer) begin
          w_tx_nxt = s_tdata;
        end
      end
      default: begin
        w_state_nxt = ST_TRAIN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_TRAIN;
      r_cnt   <= '0;
      tx_data <= '0;
      link_up <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      tx_data <= w_tx_nxt;
      link_up <= (w_state_nxt == ST_DATA);
    end
  end

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Self-checking bench for lvds_tx_framer: word-count reference model plus directed scenarios.
// The PRBS scenario is compiled in only when LVDS_TX_PRBS_EN is defined.
module tb_lvds_tx_framer;

  localparam int         TMIN = 256;
  localparam int         SREP = 4;
  localparam logic [9:0] TP   = 10'h3E0;
  localparam logic [9:0] SW   = 10'h17C;
  localparam logic [9:0] IW   = 10'h3E0;

  logic       clk = 1'b0;
  logic       reset;
  logic       train_req;
  logic       rx_aligned;
  logic       prbs_en = 1'b0;
  logic [9:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic [9:0] tx_data;
  logic       link_up;
  logic [1:0] tx_state;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  lvds_tx_framer dut (
    .clk       (clk),
    .reset     (reset),
    .train_req (train_req),
    .rx_aligned(rx_aligned),
`ifdef LVDS_TX_PRBS_EN
    .prbs_en   (prbs_en),
`endif
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .tx_data   (tx_data),
    .link_up   (link_up),
    .tx_state  (tx_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus counts of words emitted in the current preamble
  int         m_phase  = 0;
  int         m_ntrain = 0;
  int         m_nsync  = 0;
  logic [9:0] m_tx     = '0;
  logic [6:0] m_lfsr   = 7'h7F;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase  = 0;
      m_ntrain = 0;
      m_nsync  = 0;
      m_tx     = '0;
      m_lfsr   = 7'h7F;
    end else begin
      case (m_phase)
        0: begin
          m_tx = TP;
          if (m_ntrain < TMIN) m_ntrain++;
          if (m_ntrain == TMIN && rx_aligned && !train_req) begin
            m_phase = 1;
            m_nsync = 0;
          end
        end
        1: begin
          m_tx = SW;
          if (!rx_aligned || train_req) begin
            m_phase  = 0;
            m_ntrain = 0;
          end else begin
            m_nsync++;
            if (m_nsync == SREP) begin
              m_phase = 2;
              m_lfsr  = 7'h7F;
            end
          end
        end
        default: begin
          if (!rx_aligned || train_req) begin
            m_tx     = IW;
            m_phase  = 0;
            m_ntrain = 0;
          end else if (prbs_en) begin
            for (int i = 0; i < 10; i++) begin
              m_tx[9-i] = m_lfsr[6] ^ m_lfsr[5];
              m_lfsr    = {m_lfsr[5:0], m_tx[9-i]};
            end
          end else begin
            m_tx = s_tvalid ? s_tdata : IW;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_data", tx_data, m_tx);
      check("tx_state", tx_state, m_phase);
      check("link_up", link_up, m_phase == 2);
      check("s_tready", s_tready, (m_phase == 2) && !train_req && rx_aligned && !prbs_en);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_preamble(output int n_tp, output int n_sw);
    bit done = 1'b0;
    n_tp = 0;
    n_sw = 0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (tx_data == SW) n_sw++;
      else if (tx_data == TP) n_tp++;
      if (tx_state == 2'd2) begin
        done = 1'b1;
        break;
      end
    end
    check("preamble_done", done, 1);
  endtask

  task automatic wait_sync();
    bit hit = 1'b0;
    for (int c = 0; c < 600; c++) begin
      step();
      if (tx_state == 2'd1) begin
        hit = 1'b1;
        break;
      end
    end
    check("wait_sync", hit, 1);
  endtask

  int         n_tp, n_sw, idx, n_idle;
  logic [9:0] got[$];
  int         pat[16] = '{1,1,0,1,0,0,1,1,1,0,1,0,1,1,0,1};
  logic [9:0] pw[128];

  initial begin
    reset      = 1'b0;
    train_req  = 1'b0;
    rx_aligned = 1'b1;
    s_tvalid   = 1'b0;
    s_tdata    = '0;
    chk_en     = 1'b1;
    #3;
    check("rst_tx_data", tx_data, 0);
    check("rst_link_up", link_up, 0);
    check("rst_tx_state", tx_state, 0);
    check("rst_s_tready", s_tready, 0);
    step();
    reset = 1'b1;

    // Training exit
    run_preamble(n_tp, n_sw);
    check("train_words", n_tp, 256);
    check("sync_words", n_sw, 4);
    check("up_link", link_up, 1);
    check("up_state", tx_state, 2);

    // Payload bursts with gaps
    idx    = 0;
    n_idle = 0;
    for (int c = 0; c < 16; c++) begin
      s_tvalid = pat[c][0];
      s_tdata  = s_tvalid ? 10'(idx + 1) : 10'h155;
      step();
      if (s_tvalid) idx++;
      if (tx_data != IW) got.push_back(tx_data);
      else n_idle++;
    end
    s_tvalid = 1'b0;
    check("payload_count", got.size(), 10);
    check("payload_gaps", n_idle, 6);
    for (int i = 0; i < got.size(); i++) check("payload_word", got[i], i + 1);

    // Retrain pulse with a held word
    s_tvalid  = 1'b1;
    s_tdata   = 10'h0AB;
    train_req = 1'b1;
    #1;
    check("retrain_tready", s_tready, 0);
    step();
    train_req = 1'b0;
    check("retrain_state", tx_state, 0);
    check("retrain_idle", tx_data, IW);
    run_preamble(n_tp, n_sw);
    check("retrain_train_words", n_tp, 256);
    check("retrain_sync_words", n_sw, 4);
    step();
    check("held_word", tx_data, 10'h0AB);
    s_tvalid = 1'b0;
    step();
    check("held_no_dup", tx_data, IW);

    // Async reset mid-DATA
    reset = 1'b0;
    #1;
    check("arst_data_tx", tx_data, 0);
    check("arst_data_link", link_up, 0);
    check("arst_data_state", tx_state, 0);
    step();
    reset = 1'b1;

    // Alignment lost mid-SYNC restarts the whole preamble
    wait_sync();
    step();
    rx_aligned = 1'b0;
    step();
    check("abort_state", tx_state, 0);
    rx_aligned = 1'b1;
    run_preamble(n_tp, n_sw);
    check("abort_train_words", n_tp, 256);
    check("abort_sync_words", n_sw, 4);

    // Async reset mid-SYNC, between edges
    train_req = 1'b1;
    step();
    train_req = 1'b0;
    wait_sync();
    #1;
    reset = 1'b0;
    #1;
    check("arst_sync_tx", tx_data, 0);
    check("arst_sync_link", link_up, 0);
    check("arst_sync_state", tx_state, 0);
    step();
    reset = 1'b1;
    run_preamble(n_tp, n_sw);
    check("arst_train_words", n_tp, 256);
    check("arst_sync_words", n_sw, 4);

    // Late alignment at cycle 400
    rx_aligned = 1'b0;
    reset      = 1'b0;
    step();
    reset = 1'b1;
    for (int c = 0; c < 400; c++) step();
    check("late_state", tx_state, 0);
    rx_aligned = 1'b1;
    step();
    check("late_sync_next", tx_state, 1);
    check("late_last_train", tx_data, TP);
    run_preamble(n_tp, n_sw);
    check("late_extra_train", n_tp, 0);
    check("late_sync_words", n_sw, 4);

    // Held train_req keeps TRAIN with the counter saturated
    train_req = 1'b1;
    for (int c = 0; c < 300; c++) step();
    check("hold_state", tx_state, 0);
    train_req = 1'b0;
    step();
    check("hold_release_sync", tx_state, 1);
    run_preamble(n_tp, n_sw);
    check("hold_sync_words", n_sw, 4);

`ifdef LVDS_TX_PRBS_EN
    // PRBS7 from seed 7F: first ten bits are 0000001000
    prbs_en = 1'b1;
    #1;
    check("prbs_tready", s_tready, 0);
    for (int k = 0; k < 128; k++) begin
      step();
      pw[k] = tx_data;
    end
    check("prbs_first", pw[0], 10'h008);
    check("prbs_period", pw[127], pw[0]);
    check("prbs_link", link_up, 1);
    prbs_en = 1'b0;
    step();
`endif

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
